reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 142 ++++++++++++++
 tb/tb_reset_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronizes the clock-manager lock indicator and releases
// the core reset, then the peripheral reset, once lock has been stable.
module reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int STABLE_CYCLES   = 16,
  parameter int STAGE_GAP       = 4,
  parameter int SOFT_RST_CYCLES = 8,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_locked,
  input  logic             soft_rst_req,
  output logic             core_rst_n,
  output logic             periph_rst_n,
  output logic             rst_done,
  output logic [CNT_W-1:0] lock_loss_count
);

  localparam int MAX_WIN_0 = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
  localparam int MAX_WIN   = (MAX_WIN_0 > SOFT_RST_CYCLES) ? MAX_WIN_0 : SOFT_RST_CYCLES;
  localparam int CTR_W     = $clog2(MAX_WIN + 1);

  localparam logic [CTR_W-1:0] STABLE_LAST = CTR_W'(STABLE_CYCLES - 1);
  localparam logic [CTR_W-1:0] GAP_LAST    = CTR_W'(STAGE_GAP - 1);
  localparam logic [CTR_W-1:0] SOFT_LAST   = CTR_W'(SOFT_RST_CYCLES - 1);

  localparam logic [1:0] HOLD    = 2'd0;
  localparam logic [1:0] CORE_UP = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;
  localparam logic [1:0] SOFT    = 2'd3;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   locked_s;
  logic                   locked_prev_r;
  logic                   loss_s;
  logic [1:0]             state_r;
  logic [1:0]             state_nxt_s;
  logic [CTR_W-1:0]       ctr_r;
  logic [CTR_W-1:0]       ctr_nxt_s;

  assign locked_s = sync_r[SYNC_STAGES-1];
  assign loss_s   = locked_prev_r & ~locked_s;

  // Metastability chain for the asynchronous lock indicator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], clk_locked};
    end
  end

  // Next-state logic; a low lock sample overrides every other transition.
  always_comb begin
    state_nxt_s = state_r;
    ctr_nxt_s   = ctr_r;
    if (!locked_s) begin
      state_nxt_s = HOLD;
      ctr_nxt_s   = {CTR_W{1'b0}};
    end else begin
      case (state_r)
        HOLD: begin
          if (ctr_r == STABLE_LAST) begin
            state_nxt_s = CORE_UP;
            ctr_nxt_s   = {CTR_W{1'b0}};
          end else begin
            ctr_nxt_s = ctr_r + CTR_W'(1);
          end
        end
        CORE_UP: begin
          if (ctr_r == GAP_LAST) begin
            state_nxt_s = RUN;
            ctr_nxt_s   = {CTR_W{1'b0}};
          end else begin
            ctr_nxt_s = ctr_r + CTR_W'(1);
          end
        end
        RUN: begin
          if (soft_rst_req) begin
            state_nxt_s = SOFT;
            ctr_nxt_s   = {CTR_W{1'b0}};
          end else begin
            state_nxt_s = RUN;
          end
        end
        SOFT: begin
          if (ctr_r == SOFT_LAST) begin
            state_nxt_s = HOLD;
            ctr_nxt_s   = {CTR_W{1'b0}};
          end else begin
            ctr_nxt_s = ctr_r + CTR_W'(1);
          end
        end
        default: begin
          state_nxt_s = HOLD;
          ctr_nxt_s   = {CTR_W{1'b0}};
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= HOLD;
      ctr_r   <= {CTR_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      ctr_r   <= ctr_nxt_s;
    end
  end

  // Resets are decoded from the next state so they switch on the transition edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rst_n   <= 1'b0;
      periph_rst_n <= 1'b0;
      rst_done     <= 1'b0;
    end else begin
      core_rst_n   <= (state_nxt_s == CORE_UP) || (state_nxt_s == RUN);
      periph_rst_n <= (state_nxt_s == RUN);
      rst_done     <= (state_nxt_s == RUN);
    end
  end

  // Saturating count of falling edges of the synchronized lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_prev_r   <= 1'b0;
      lock_loss_count <= {CNT_W{1'b0}};
    end else begin
      locked_prev_r <= locked_s;
      if (loss_s && (lock_loss_count != {CNT_W{1'b1}})) begin
        lock_loss_count <= lock_loss_count + CNT_W'(1);
      end else begin
        lock_loss_count <= lock_loss_count;
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed vector table, hand-written corner
// sequences and randomized lock/soft-reset traffic against a timing model.
module tb_reset_sequencer;

  localparam int SYNC   = 2;
  localparam int STABLE = 16;
  localparam int GAP    = 4;
  localparam int SOFT   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_locked = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       core_rst_n, periph_rst_n, rst_done;
  logic [7:0] cnt;
  logic       core2, periph2, done2;
  logic [1:0] cnt2;

  int n_checks = 0;
  int n_pass   = 0;

  reset_sequencer dut (
    .clk(clk), .rst_n(rst_n), .clk_locked(clk_locked), .soft_rst_req(soft_rst_req),
    .core_rst_n(core_rst_n), .periph_rst_n(periph_rst_n), .rst_done(rst_done),
    .lock_loss_count(cnt)
  );

  reset_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clk_locked(clk_locked), .soft_rst_req(soft_rst_req),
    .core_rst_n(core2), .periph_rst_n(periph2), .rst_done(done2),
    .lock_loss_count(cnt2)
  );

  always #5 clk = ~clk;

  // Timing model: tracks how long lock has been stable and when the core was
  // released, rather than any particular state encoding.
  logic m_pipe [SYNC];
  logic m_prev;
  int   m_cnt, streak, soft_left, rel_at, edge_n;
  logic m_core, m_periph;

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
    m_prev = 1'b0; m_cnt = 0; streak = 0; soft_left = 0; rel_at = -1;
    m_core = 1'b0; m_periph = 1'b0;
  endtask

  task automatic model_edge(input logic lk, input logic sr);
    logic ls;
    edge_n++;
    ls = m_pipe[SYNC-1];
    for (int i = SYNC-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = lk;
    if (m_prev && !ls) m_cnt++;
    m_prev = ls;
    if (!ls) begin
      streak = 0; rel_at = -1; soft_left = 0;
    end else if (soft_left > 0) begin
      soft_left--; streak = 0;
    end else if (rel_at < 0) begin
      streak++;
      if (streak == STABLE) begin rel_at = edge_n; streak = 0; end
    end else if (sr && (edge_n - 1 - rel_at) >= GAP) begin
      soft_left = SOFT; rel_at = -1;
    end
    m_core   = (rel_at >= 0);
    m_periph = (rel_at >= 0) && (edge_n - rel_at >= GAP);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_model();
    check("mdl core", int'(core_rst_n), int'(m_core));
    check("mdl periph", int'(periph_rst_n), int'(m_periph));
    check("mdl done", int'(rst_done), int'(m_periph));
    check("mdl cnt", int'(cnt), (m_cnt > 255) ? 255 : m_cnt);
    check("mdl cnt2", int'(cnt2), (m_cnt > 3) ? 3 : m_cnt);
  endtask

  task automatic step(input logic lk, input logic sr);
    clk_locked = lk;
    soft_rst_req = sr;
    @(posedge clk);
    model_edge(lk, sr);
    #1;
    check_model();
  endtask

  task automatic hold_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    repeat (n) @(posedge clk);
    #1;
    clk_locked = 1'b0;
    rst_n = 1'b1;
  endtask

  typedef struct {
    int   n;
    logic lk;
    logic sr;
    logic core;
    logic periph;
    int   cnt;
  } vec_t;

  vec_t vecs [26];

  initial begin
    edge_n = 0;
    model_reset();

    // Power-up, soft reset, lock loss/relock, lock loss coinciding with soft request.
    vecs[0]  = '{17, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[1]  = '{ 1, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[2]  = '{ 3, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[3]  = '{ 1, 1'b1, 1'b0, 1'b1, 1'b1, 0};
    vecs[4]  = '{ 5, 1'b1, 1'b0, 1'b1, 1'b1, 0};
    vecs[5]  = '{ 1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[6]  = '{ 7, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[7]  = '{ 1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[8]  = '{15, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[9]  = '{ 1, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[10] = '{ 3, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[11] = '{ 1, 1'b1, 1'b0, 1'b1, 1'b1, 0};
    vecs[12] = '{ 2, 1'b0, 1'b0, 1'b1, 1'b1, 0};
    vecs[13] = '{ 1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[14] = '{17, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[15] = '{ 1, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[16] = '{ 3, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[17] = '{ 1, 1'b1, 1'b0, 1'b1, 1'b1, 1};
    vecs[18] = '{ 1, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    vecs[19] = '{ 1, 1'b1, 1'b0, 1'b1, 1'b1, 1};
    vecs[20] = '{ 1, 1'b1, 1'b1, 1'b0, 1'b0, 2};
    vecs[21] = '{15, 1'b1, 1'b1, 1'b0, 1'b0, 2};
    vecs[22] = '{ 1, 1'b1, 1'b1, 1'b1, 1'b0, 2};
    vecs[23] = '{ 3, 1'b1, 1'b1, 1'b1, 1'b0, 2};
    vecs[24] = '{ 1, 1'b1, 1'b0, 1'b1, 1'b1, 2};
    vecs[25] = '{ 2, 1'b1, 1'b0, 1'b1, 1'b1, 2};

    hold_reset(3);
    check("reset core", int'(core_rst_n), 0);
    check("reset periph", int'(periph_rst_n), 0);
    check("reset done", int'(rst_done), 0);
    check("reset cnt", int'(cnt), 0);

    for (int i = 0; i < 26; i++) begin
      for (int k = 0; k < vecs[i].n; k++) step(vecs[i].lk, vecs[i].sr);
      check($sformatf("vec%0d core", i), int'(core_rst_n), int'(vecs[i].core));
      check($sformatf("vec%0d periph", i), int'(periph_rst_n), int'(vecs[i].periph));
      check($sformatf("vec%0d done", i), int'(rst_done), int'(vecs[i].periph));
      check($sformatf("vec%0d cnt", i), int'(cnt), vecs[i].cnt);
    end

    // Lock glitch during the stable window: 10 high, 3 low, then steady.
    hold_reset(2);
    repeat (10) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    repeat (17) step(1'b1, 1'b0);
    check("glitch core held", int'(core_rst_n), 0);
    check("glitch cnt", int'(cnt), 1);
    step(1'b1, 1'b0);
    check("glitch core up", int'(core_rst_n), 1);

    // Five more lock losses: narrow counter saturates at 3.
    for (int g = 0; g < 5; g++) begin
      repeat (3) step(1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0);
    end
    check("sat cnt8", int'(cnt), 6);
    check("sat cnt2", int'(cnt2), 3);

    // Asynchronous reset in the middle of CORE_UP acts without a clock edge.
    repeat (16) step(1'b1, 1'b0);
    check("pre-async core", int'(core_rst_n), 1);
    check("pre-async periph", int'(periph_rst_n), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async core", int'(core_rst_n), 0);
    check("async periph", int'(periph_rst_n), 0);
    check("async done", int'(rst_done), 0);
    check("async cnt", int'(cnt), 0);
    check("async cnt2", int'(cnt2), 0);
    hold_reset(2);

    // Randomized lock drops, soft requests and occasional async resets.
    begin
      logic lk;
      lk = 1'b1;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 39) == 0) lk = ~lk;
        if ($urandom_range(0, 999) == 0) hold_reset($urandom_range(1, 3));
        else step(lk, ($urandom_range(0, 15) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
